// File: rtl/multi_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_event_counter
// Description : NCH-channel event counter with per-channel prescale divisor,
//               wrap/saturate mode, sticky overflow and one-cycle step ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_event_counter #(
    parameter int WIDTH = 64,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int PREW  = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   En,
    input  logic [SELW-1:0]        Slt,
    input  logic                   Clr,
    input  logic                   Cfg_we,
    input  logic [SELW-1:0]        Cfg_ch,
    input  logic [PREW-1:0]        Cfg_div,
    input  logic                   Cfg_sat,
    output logic [NCH*WIDTH-1:0]   Count,
    output logic [NCH-1:0]         Ovf,
    output logic [NCH-1:0]         Tick
);

    genvar i;
    generate
        for (i = 0; i < NCH; i = i + 1) begin : g_ch
            localparam logic [SELW-1:0] C_ID = SELW'(i);

            logic [WIDTH-1:0] r_cnt;
            logic [PREW-1:0]  r_pre;
            logic [PREW-1:0]  r_div;
            logic             r_sat;
            logic             r_ovf;
            logic             r_tick;

            logic w_cfg_hit;
            logic w_clr_hit;
            logic w_ev_hit;
            logic w_pre_done;
            logic w_at_max;

            // Out-of-range selects never match any C_ID, so they are ignored.
            assign w_cfg_hit  = Cfg_we && (Cfg_ch == C_ID);
            assign w_clr_hit  = Clr && (Slt == C_ID);
            assign w_ev_hit   = En && (Slt == C_ID) && !w_clr_hit && !w_cfg_hit;
            assign w_pre_done = (r_pre == r_div);
            assign w_at_max   = &r_cnt;

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    r_cnt  <= '0;
                    r_pre  <= '0;
                    r_div  <= '0;
                    r_sat  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= 1'b0;
                    if (w_cfg_hit) begin
                        r_div <= Cfg_div;
                        r_sat <= Cfg_sat;
                        r_pre <= '0;
                    end
                    // A config write to the same channel does not block a clear.
                    if (w_clr_hit) begin
                        r_cnt <= '0;
                        r_pre <= '0;
                        r_ovf <= 1'b0;
                    end else if (w_ev_hit) begin
                        if (w_pre_done) begin
                            r_pre <= '0;
                            if (w_at_max) begin
                                r_ovf <= 1'b1;
                                if (!r_sat) begin
                                    r_cnt  <= '0;
                                    r_tick <= 1'b1;
                                end
                            end else begin
                                r_cnt  <= r_cnt + WIDTH'(1);
                                r_tick <= 1'b1;
                            end
                        end else begin
                            r_pre <= r_pre + PREW'(1);
                        end
                    end
                end
            end

            assign Count[i*WIDTH +: WIDTH] = r_cnt;
            assign Ovf[i]                  = r_ovf;
            assign Tick[i]                 = r_tick;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_event_counter
// Description : Directed and random stimulus against a channel-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_event_counter;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 3;
    localparam int PREW  = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 En = 1'b0;
    logic [SELW-1:0]      Slt = '0;
    logic                 Clr = 1'b0;
    logic                 Cfg_we = 1'b0;
    logic [SELW-1:0]      Cfg_ch = '0;
    logic [PREW-1:0]      Cfg_div = '0;
    logic                 Cfg_sat = 1'b0;
    logic [NCH*WIDTH-1:0] Count;
    logic [NCH-1:0]       Ovf;
    logic [NCH-1:0]       Tick;

    multi_event_counter #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW),
        .PREW  (PREW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .En      (En),
        .Slt     (Slt),
        .Clr     (Clr),
        .Cfg_we  (Cfg_we),
        .Cfg_ch  (Cfg_ch),
        .Cfg_div (Cfg_div),
        .Cfg_sat (Cfg_sat),
        .Count   (Count),
        .Ovf     (Ovf),
        .Tick    (Tick)
    );

    always #5 Clk = ~Clk;

    // Model: events seen since last step, compared against the divisor count.
    int m_cnt  [NCH];
    int m_seen [NCH];
    int m_div  [NCH];
    bit m_sat  [NCH];
    bit m_ovf  [NCH];
    bit m_tick [NCH];
    int tick_total [NCH];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic model_edge();
        if (!Reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_seen[c] = 0; m_div[c] = 0;
                m_sat[c] = 0; m_ovf[c] = 0; m_tick[c] = 0;
            end
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            bit cfg, clr, ev;
            cfg = Cfg_we && (int'(Cfg_ch) == c);
            clr = Clr && (int'(Slt) == c);
            ev  = En && (int'(Slt) == c) && !clr && !cfg;
            m_tick[c] = 0;
            if (cfg) begin
                m_div[c]  = int'(Cfg_div);
                m_sat[c]  = Cfg_sat;
                m_seen[c] = 0;
            end
            if (clr) begin
                m_cnt[c] = 0; m_seen[c] = 0; m_ovf[c] = 0;
            end
            if (ev) begin
                m_seen[c] = m_seen[c] + 1;
                if (m_seen[c] == m_div[c] + 1) begin
                    m_seen[c] = 0;
                    if (m_cnt[c] == MAXV) begin
                        m_ovf[c] = 1;
                        if (!m_sat[c]) begin
                            m_cnt[c] = 0;
                            m_tick[c] = 1;
                        end
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                        m_tick[c] = 1;
                    end
                end
            end
            if (m_tick[c]) tick_total[c] = tick_total[c] + 1;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            logic [WIDTH-1:0] obs_cnt;
            logic [WIDTH-1:0] exp_cnt;
            obs_cnt = Count[c*WIDTH +: WIDTH];
            exp_cnt = WIDTH'(m_cnt[c]);
            n_assert++;
            assert (obs_cnt === exp_cnt) else begin
                n_fail++;
                $error("FAIL count[%0d] observed=%0d expected=%0d t=%0t", c, obs_cnt, exp_cnt, $time);
            end
            n_assert++;
            assert (Ovf[c] === m_ovf[c]) else begin
                n_fail++;
                $error("FAIL ovf[%0d] observed=%b expected=%b t=%0t", c, Ovf[c], m_ovf[c], $time);
            end
            n_assert++;
            assert (Tick[c] === m_tick[c]) else begin
                n_fail++;
                $error("FAIL tick[%0d] observed=%b expected=%b t=%0t", c, Tick[c], m_tick[c], $time);
            end
        end
    endtask

    task automatic check_const(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check after it.
    task automatic cyc(input bit rn, input bit en, input int slt, input bit clr,
                       input bit we, input int ch, input int dv, input bit st);
        Reset_n = rn; En = en; Slt = SELW'(slt); Clr = clr;
        Cfg_we = we; Cfg_ch = SELW'(ch); Cfg_div = PREW'(dv); Cfg_sat = st;
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic events(input int ch, input int n);
        for (int k = 0; k < n; k++) cyc(1, 1, ch, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) tick_total[c] = 0;

        // Reset with En asserted
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check_const("reset_count0", int'(Count[0 +: WIDTH]), 0);
        check_const("reset_tick", int'(Tick), 0);

        // div=0 on channel 0: five counted events
        tick_total[0] = 0;
        events(0, 5);
        idle();
        check_const("ch0_count5", int'(Count[0 +: WIDTH]), 5);
        check_const("ch0_ticks5", tick_total[0], 5);
        check_const("ch1_untouched", int'(Count[WIDTH +: WIDTH]), 0);

        // Channel 1 with divisor 4
        cyc(1, 0, 0, 0, 1, 1, 3, 0);
        tick_total[1] = 0;
        events(1, 8);
        idle();
        check_const("ch1_div4_count", int'(Count[WIDTH +: WIDTH]), 2);
        check_const("ch1_div4_ticks", tick_total[1], 2);

        // Channel 2 wrap mode
        events(2, 255);
        check_const("ch2_preload", int'(Count[2*WIDTH +: WIDTH]), 255);
        events(2, 1);
        check_const("ch2_wrap_count", int'(Count[2*WIDTH +: WIDTH]), 0);
        check_const("ch2_wrap_ovf", int'(Ovf[2]), 1);
        cyc(1, 0, 2, 1, 0, 0, 0, 0);
        check_const("ch2_clr_ovf", int'(Ovf[2]), 0);

        // Channel 3 saturate mode
        cyc(1, 0, 0, 0, 1, 3, 0, 1);
        tick_total[3] = 0;
        events(3, 300);
        check_const("ch3_sat_count", int'(Count[3*WIDTH +: WIDTH]), 255);
        check_const("ch3_sat_ovf", int'(Ovf[3]), 1);
        check_const("ch3_sat_ticks", tick_total[3], 255);

        // Switch sat->wrap at all-ones: next step wraps
        cyc(1, 0, 0, 0, 1, 3, 0, 0);
        events(3, 1);
        check_const("ch3_sat2wrap", int'(Count[3*WIDTH +: WIDTH]), 0);

        // Same-cycle collisions
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        check_const("ch0_clr_en", int'(Count[0 +: WIDTH]), 0);
        cyc(1, 0, 0, 0, 1, 1, 1, 0);
        events(1, 1);
        cyc(1, 1, 1, 0, 1, 1, 1, 0);
        events(1, 1);
        check_const("ch1_cfg_drop", int'(Count[WIDTH +: WIDTH]), 2);
        events(1, 1);
        check_const("ch1_after_drop", int'(Count[WIDTH +: WIDTH]), 3);
        cyc(1, 1, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 5, 1, 1, 6, 2, 1);
        cyc(1, 1, 2, 1, 1, 2, 3, 1);

        // Random traffic, including out-of-range selects and rare resets
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
